// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates ECALL/EBREAK, M-mode interrupts and MRET, then drains.
// Optional TRAP_VECTORED_EN: interrupts use mtvec vectored mode when mtvec[1:0]==2'b01.
module trap_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      irq_pending,
  input  logic [2:0]      mie_bits,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ecall_exception,
  input  logic            ebreak_exception,
  input  logic            mret_instruction,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            interrupt_pending,
  output logic [XLEN-1:0] interrupt_cause,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target,
  output logic            csr_trap_we,
  output logic [XLEN-1:0] csr_mepc_wdata,
  output logic [XLEN-1:0] csr_mcause_wdata,
  output logic            mstatus_we,
  output logic            mstatus_mie_next,
  output logic            mstatus_mpie_next,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ENTRY, RETURN, DRAIN} state_t;

  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_MEI    = {1'b1, (XLEN-1)'(11)};
  localparam logic [XLEN-1:0] CAUSE_MSI    = {1'b1, (XLEN-1)'(3)};
  localparam logic [XLEN-1:0] CAUSE_MTI    = {1'b1, (XLEN-1)'(7)};

  state_t          state;
  logic [3:0]      drain_cnt;

  logic [2:0]      irq_active;
  logic            irq_eligible;
  logic            take_trap;
  logic            take_irq;
  logic            take_mret;
  logic [XLEN-1:0] sel_cause;
  logic [XLEN-1:0] base_target;
  logic [XLEN-1:0] entry_target;
  logic            unused_low_bits;

  assign unused_low_bits = ^{ex_pc[1:0], mepc[1:0], mtvec[1:0]};
  assign base_target     = {mtvec[XLEN-1:2], 2'b00};

  // Exceptions outrank interrupts; an interrupt outranks MRET, which re-executes afterwards.
  always_comb begin
    irq_active   = irq_pending & mie_bits;
    irq_eligible = mstatus_mie & (|irq_active) & ex_valid;
    take_irq     = 1'b0;
    take_mret    = 1'b0;
    take_trap    = 1'b1;
    sel_cause    = '0;
    if (ex_valid && ecall_exception) begin
      sel_cause = CAUSE_ECALL;
    end else if (ex_valid && ebreak_exception) begin
      sel_cause = CAUSE_EBREAK;
    end else if (irq_eligible) begin
      take_irq  = 1'b1;
      sel_cause = irq_active[2] ? CAUSE_MEI : (irq_active[0] ? CAUSE_MSI : CAUSE_MTI);
    end else if (ex_valid && mret_instruction) begin
      take_mret = 1'b1;
      take_trap = 1'b0;
    end else begin
      take_trap = 1'b0;
    end
  end

  always_comb begin
    entry_target = base_target;
`ifdef TRAP_VECTORED_EN
    if (take_irq && mtvec[1:0] == 2'b01)
      entry_target = base_target + XLEN'({sel_cause[4:0], 2'b00});
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      drain_cnt         <= '0;
      interrupt_pending <= 1'b0;
      interrupt_cause   <= '0;
      trap_redirect     <= 1'b0;
      trap_target       <= '0;
      csr_trap_we       <= 1'b0;
      csr_mepc_wdata    <= '0;
      csr_mcause_wdata  <= '0;
      mstatus_we        <= 1'b0;
      mstatus_mie_next  <= 1'b0;
      mstatus_mpie_next <= 1'b0;
      busy              <= 1'b0;
    end else begin
      // Strobes are single-cycle: they only rise on the edge leaving IDLE.
      interrupt_pending <= 1'b0;
      trap_redirect     <= 1'b0;
      csr_trap_we       <= 1'b0;
      mstatus_we        <= 1'b0;
      case (state)
        IDLE: begin
          if (take_trap) begin
            state             <= ENTRY;
            busy              <= 1'b1;
            interrupt_cause   <= sel_cause;
            interrupt_pending <= take_irq;
            csr_trap_we       <= 1'b1;
            csr_mepc_wdata    <= {ex_pc[XLEN-1:2], 2'b00};
            csr_mcause_wdata  <= sel_cause;
            mstatus_we        <= 1'b1;
            mstatus_mie_next  <= 1'b0;
            mstatus_mpie_next <= mstatus_mie;
            trap_redirect     <= 1'b1;
            trap_target       <= entry_target;
          end else if (take_mret) begin
            state             <= RETURN;
            busy              <= 1'b1;
            interrupt_cause   <= '0;
            mstatus_we        <= 1'b1;
            mstatus_mie_next  <= mstatus_mpie;
            mstatus_mpie_next <= 1'b1;
            trap_redirect     <= 1'b1;
            trap_target       <= {mepc[XLEN-1:2], 2'b00};
          end
        end
        ENTRY, RETURN: begin
          state     <= DRAIN;
          drain_cnt <= 4'(FLUSH_CYCLES);
        end
        DRAIN: begin
          // Counter hits zero on the same edge that returns to IDLE: FLUSH_CYCLES drain cycles.
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt <= 4'd1) begin
            state     <= IDLE;
            busy      <= 1'b0;
            drain_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: expected redirects are queued, a negedge monitor checks them.
module tb_trap_controller;

  localparam int XLEN  = 32;
  localparam int FLUSH = 2;
  localparam int W     = 4 + 3 * XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      irq_pending = '0;
  logic [2:0]      mie_bits = '0;
  logic            mstatus_mie = 1'b0;
  logic            mstatus_mpie = 1'b0;
  logic            ex_valid = 1'b0;
  logic [XLEN-1:0] ex_pc = '0;
  logic            ecall_exception = 1'b0;
  logic            ebreak_exception = 1'b0;
  logic            mret_instruction = 1'b0;
  logic [XLEN-1:0] mtvec = '0;
  logic [XLEN-1:0] mepc = '0;
  logic            interrupt_pending;
  logic [XLEN-1:0] interrupt_cause;
  logic            trap_redirect;
  logic [XLEN-1:0] trap_target;
  logic            csr_trap_we;
  logic [XLEN-1:0] csr_mepc_wdata;
  logic [XLEN-1:0] csr_mcause_wdata;
  logic            mstatus_we;
  logic            mstatus_mie_next;
  logic            mstatus_mpie_next;
  logic            busy;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  trap_controller #(.FLUSH_CYCLES(FLUSH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .irq_pending(irq_pending), .mie_bits(mie_bits),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ecall_exception(ecall_exception), .ebreak_exception(ebreak_exception),
    .mret_instruction(mret_instruction), .mtvec(mtvec), .mepc(mepc),
    .interrupt_pending(interrupt_pending), .interrupt_cause(interrupt_cause),
    .trap_redirect(trap_redirect), .trap_target(trap_target),
    .csr_trap_we(csr_trap_we), .csr_mepc_wdata(csr_mepc_wdata),
    .csr_mcause_wdata(csr_mcause_wdata), .mstatus_we(mstatus_we),
    .mstatus_mie_next(mstatus_mie_next), .mstatus_mpie_next(mstatus_mpie_next),
    .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic irqp, input logic twe, input logic mie_n,
                                      input logic mpie_n, input logic [XLEN-1:0] epc_w,
                                      input logic [XLEN-1:0] cause_w, input logic [XLEN-1:0] tgt);
    return {irqp, twe, mie_n, mpie_n, epc_w, cause_w, tgt};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      if (trap_redirect) begin
        if (exp_q.size() == 0) begin
          check("unexpected_redirect", 32'(trap_redirect), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("interrupt_pending", 32'(interrupt_pending), 32'(e[W-1]));
          check("csr_trap_we", 32'(csr_trap_we), 32'(e[W-2]));
          check("mstatus_we", 32'(mstatus_we), 32'd1);
          check("mstatus_mie_next", 32'(mstatus_mie_next), 32'(e[W-3]));
          check("mstatus_mpie_next", 32'(mstatus_mpie_next), 32'(e[W-4]));
          check("trap_target", trap_target, e[XLEN-1:0]);
          if (e[W-2]) begin
            check("csr_mepc_wdata", csr_mepc_wdata, e[3*XLEN-1:2*XLEN]);
            check("csr_mcause_wdata", csr_mcause_wdata, e[2*XLEN-1:XLEN]);
            check("interrupt_cause", interrupt_cause, e[2*XLEN-1:XLEN]);
          end
        end
      end else begin
        check("strobes_without_redirect", 32'({csr_trap_we, mstatus_we, interrupt_pending}), 32'd0);
      end
    end
  end

  // driver tasks: inputs are set at a negedge, the DUT samples at the next posedge
  task automatic take(input logic [W-1:0] e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clear_req();
    ecall_exception  = 1'b0;
    ebreak_exception = 1'b0;
    mret_instruction = 1'b0;
    irq_pending      = '0;
    ex_valid         = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check(name, 32'(cnt), 32'(1 + FLUSH));
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, 32'(busy), 32'd0);
    end
  endtask

  logic [XLEN-1:0] vec_target;

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({interrupt_pending, trap_redirect, csr_trap_we, mstatus_we,
                                mstatus_mie_next, mstatus_mpie_next, busy}), 32'd0);
    check("reset_target", trap_target | csr_mepc_wdata | csr_mcause_wdata | interrupt_cause, 32'd0);
    rst = 1'b0;
    idle_cycles(2, "idle_after_reset");

    // ECALL
    mtvec = 32'h200; mstatus_mie = 1'b1; mie_bits = 3'b111;
    ex_valid = 1'b1; ecall_exception = 1'b1; ex_pc = 32'h100;
    take(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'd11, 32'h200));
    clear_req();
    wait_idle("ecall_busy_cycles");

    // timer interrupt blocked by mstatus.MIE=0
    mstatus_mie = 1'b0; irq_pending = 3'b010; ex_valid = 1'b1; ex_pc = 32'h40;
    idle_cycles(3, "mie0_no_action");

    // timer interrupt taken
    mstatus_mie = 1'b1;
    take(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h8000_0007, 32'h200));
    clear_req();
    wait_idle("mti_busy_cycles");

    // EBREAK with all interrupts pending; misaligned PC is masked
    ex_valid = 1'b1; ebreak_exception = 1'b1; irq_pending = 3'b111; ex_pc = 32'h82;
    take(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'd3, 32'h200));
    ebreak_exception = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h8000_000B, 32'h200));
    wait_idle("ebreak_busy_cycles");
    @(negedge clk);
    clear_req();
    wait_idle("mei_busy_cycles");

    // MRET
    mstatus_mie = 1'b0; mstatus_mpie = 1'b1; mepc = 32'h46;
    ex_valid = 1'b1; mret_instruction = 1'b1; ex_pc = 32'h90;
    take(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h44));
    clear_req();
    wait_idle("mret_busy_cycles");

    // MRET coincident with eligible MTI: interrupt wins
    mstatus_mie = 1'b1; mepc = 32'h44;
    ex_valid = 1'b1; mret_instruction = 1'b1; irq_pending = 3'b010; ex_pc = 32'h48;
    take(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h48, 32'h8000_0007, 32'h200));
    clear_req();
    wait_idle("mret_irq_busy_cycles");

    // vectored mtvec
`ifdef TRAP_VECTORED_EN
    vec_target = 32'h32C;
`else
    vec_target = 32'h300;
`endif
    mtvec = 32'h301;
    ex_valid = 1'b1; irq_pending = 3'b100; ex_pc = 32'h50;
    take(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 32'h8000_000B, vec_target));
    clear_req();
    wait_idle("vec_irq_busy_cycles");
    ex_valid = 1'b1; ecall_exception = 1'b1; ex_pc = 32'h54;
    take(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h54, 32'd11, 32'h300));
    clear_req();
    wait_idle("vec_ecall_busy_cycles");

    // reset during DRAIN
    mtvec = 32'h200;
    ex_valid = 1'b1; ecall_exception = 1'b1; ex_pc = 32'h60;
    take(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h60, 32'd11, 32'h200));
    clear_req();
    @(negedge clk);
    check("in_drain_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drain_busy", 32'(busy), 32'd0);
    check("rst_drain_strobes", 32'({trap_redirect, csr_trap_we, mstatus_we, interrupt_pending}), 32'd0);
    rst = 1'b0;
    idle_cycles(3, "idle_after_mid_reset");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
